// File: rtl/tanh_segment_fetcher_if.sv
// tanh_segment_fetcher_if: input and output handshake bundle for the tanh segment fetcher
interface tanh_segment_fetcher_if #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] x;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] next_data;
    logic [DATA_W-1:0] change;
    logic [FRAC_W-1:0] remaining;
    logic              saturated;

    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, base, next_data, change, remaining, saturated
    );

    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, base, next_data, change, remaining, saturated
    );
endinterface

// File: rtl/tanh_segment_fetcher.sv
// tanh_segment_fetcher: splits |x| into segment/remainder and fetches signed tanh endpoints
module tanh_segment_fetcher #(
    parameter int DATA_W  = 8,
    parameter int FRAC_W  = 4,
    parameter int NUM_SEG = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    tanh_segment_fetcher_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SEG + 1);
    localparam logic [DATA_W:0] SAT_MAG = (DATA_W + 1)'(NUM_SEG << FRAC_W);

    logic                     s1_valid;
    logic                     s1_sign;
    logic                     s1_sat;
    logic [IDX_W-1:0]         s1_idx;
    logic [FRAC_W-1:0]        s1_rem;
    logic                     s1_adv;
    logic                     s2_adv;
    logic                     sign;
    logic                     sat;
    logic [DATA_W:0]          mag;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         nidx;
    logic signed [DATA_W-1:0] t_b;
    logic signed [DATA_W-1:0] t_n;
    logic signed [DATA_W-1:0] b;
    logic signed [DATA_W-1:0] n;

    function automatic logic signed [DATA_W-1:0] rom(input logic [IDX_W-1:0] i);
        return i == IDX_W'(0) ? DATA_W'(0) :
               i == IDX_W'(1) ? DATA_W'(49) :
               i == IDX_W'(2) ? DATA_W'(62) : DATA_W'(64);
    endfunction

    // magnitude split of the incoming x, endpoint lookup for stage 1, and handshake advance terms
    always_comb begin
        sign = bus.x[DATA_W-1];
        mag = sign ? -{sign, bus.x} : {sign, bus.x};
        sat = mag >= SAT_MAG;
        idx = sat ? IDX_W'(NUM_SEG) : mag[FRAC_W +: IDX_W];
        nidx = s1_sat ? s1_idx : s1_idx + 1'b1;
        t_b = rom(s1_idx);
        t_n = rom(nidx);
        b = s1_sign ? -t_b : t_b;
        n = s1_sign ? -t_n : t_n;
        s2_adv = !bus.out_valid || bus.out_ready;
        s1_adv = !s1_valid || s2_adv;
        bus.in_ready = s1_adv;
    end

    // stage 1: register sign, segment index and remainder (clamped when saturated)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_sat   <= 1'b0;
            s1_idx   <= '0;
            s1_rem   <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            s1_sign  <= sign;
            s1_sat   <= sat;
            s1_idx   <= idx;
            s1_rem   <= sat ? '0 : mag[FRAC_W-1:0];
        end
    end

    // stage 2: output register, held while the interpolator stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.base      <= '0;
            bus.next_data <= '0;
            bus.change    <= '0;
            bus.remaining <= '0;
            bus.saturated <= 1'b0;
        end else if (s2_adv) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.base      <= b;
                bus.next_data <= n;
                bus.change    <= n - b;
                bus.remaining <= s1_rem;
                bus.saturated <= s1_sat;
            end
        end
    end
endmodule

// File: tb/tb_tanh_segment_fetcher.sv
// tb_tanh_segment_fetcher: scoreboard bench for the tanh segment fetcher
module tb_tanh_segment_fetcher;
    typedef struct packed {
        logic [7:0] base;
        logic [7:0] next_data;
        logic [7:0] change;
        logic [3:0] rem;
        logic       sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   stalls = 0;
    exp_t sb[$];

    tanh_segment_fetcher_if #(.DATA_W(8), .FRAC_W(4)) bus ();

    tanh_segment_fetcher #(.DATA_W(8), .FRAC_W(4), .NUM_SEG(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [7:0] v);
        int   t[5] = '{0, 49, 62, 64, 64};
        int   m;
        int   idx;
        int   tb;
        int   tn;
        exp_t e;
        m = v[7] ? 256 - int'(v) : int'(v);
        e.sat = m >= 64;
        idx = e.sat ? 4 : m / 16;
        e.rem = e.sat ? 4'd0 : 4'(m % 16);
        tb = t[idx];
        tn = e.sat ? t[idx] : t[idx + 1];
        if (v[7]) begin
            tb = -tb;
            tn = -tn;
        end
        e.base = 8'(tb);
        e.next_data = 8'(tn);
        e.change = 8'(tn - tb);
        return e;
    endfunction

    // scoreboard: push on accept, pop and compare on emit; reset discards in-flight items
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) sb.delete();
        else begin
            if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.x));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) check("unexpected_output", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("base", 32'(bus.base), 32'(e.base));
                    check("next_data", 32'(bus.next_data), 32'(e.next_data));
                    check("change", 32'(bus.change), 32'(e.change));
                    check("remaining", 32'(bus.remaining), 32'(e.rem));
                    check("saturated", 32'(bus.saturated), 32'(e.sat));
                end
            end
        end
    end

    task automatic send(input logic [7:0] v, input bit rand_rdy);
        bit acc;
        int t = 0;
        bus.x = v;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
            if (acc) break;
            stalls++;
            if (++t > 200) begin
                check("send_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", 32'(sb.size()), 0);
    endtask

    task automatic one(input logic [7:0] v, input logic [7:0] b, input logic [7:0] n,
                       input logic [7:0] c, input logic [3:0] r, input logic s);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.x = v;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("lat_early", 32'(bus.out_valid), 0);
        @(negedge clk);
        check("lat_valid", 32'(bus.out_valid), 1);
        check("dir_base", 32'(bus.base), 32'(b));
        check("dir_next", 32'(bus.next_data), 32'(n));
        check("dir_change", 32'(bus.change), 32'(c));
        check("dir_rem", 32'(bus.remaining), 32'(r));
        check("dir_sat", 32'(bus.saturated), 32'(s));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t snap;
        int   acc;
        bus.in_valid = 1'b0;
        bus.x = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_outputs", {bus.base, bus.next_data, bus.change, bus.remaining, bus.saturated}, 0);

        one(8'h18, 8'd49, 8'd62, 8'd13, 4'd8, 1'b0);
        one(8'hE8, 8'hCF, 8'hC2, 8'hF3, 4'd8, 1'b0);
        one(8'h50, 8'd64, 8'd64, 8'd0, 4'd0, 1'b1);
        one(8'h80, 8'hC0, 8'hC0, 8'd0, 4'd0, 1'b1);
        one(8'h00, 8'd0, 8'd49, 8'd49, 4'd0, 1'b0);
        one(8'h3F, 8'd64, 8'd64, 8'd0, 4'd15, 1'b0);
        one(8'hC0, 8'hC0, 8'hC0, 8'd0, 4'd0, 1'b1);
        drain();

        stalls = 0;
        for (int i = 0; i < 64; i++) send(8'(i), 1'b0);
        check("stream_stalls", 32'(stalls), 0);
        drain();

        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            bus.x = 8'(8'h18 + 8'(k * 16));
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
            if (k == 2) snap = {bus.base, bus.next_data, bus.change, bus.remaining, bus.saturated};
            if (k > 2) check("stall_stable", {bus.base, bus.next_data, bus.change, bus.remaining, bus.saturated}, 32'(snap));
            if (k >= 2) check("stall_valid", 32'(bus.out_valid), 1);
            @(posedge clk);
            #1;
        end
        check("stall_accepts", 32'(acc), 2);
        check("stall_in_ready", 32'(bus.in_ready), 0);
        drain();

        for (int i = 0; i < 150; i++) send(8'($urandom), 1'b1);
        send(8'h80, 1'b1);
        send(8'h7F, 1'b1);
        drain();

        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.x = 8'h18;
        @(posedge clk);
        #1;
        bus.x = 8'h28;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 32'(bus.out_valid), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 32'(bus.out_valid), 0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_stale", 32'(bus.out_valid), 0);
        end
        one(8'hD8, 8'hC2, 8'hC0, 8'hFE, 4'd8, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
